// File: rtl/quadrature_pkg.sv
// Shared FSM state, quadrature transition decode and direction constants.
// Pure definitions; no timing or flow control.
package quadrature_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UP,
    TR_DN,
    TR_ILL
  } trans_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // {A,B} walks 00 -> 10 -> 11 -> 01 -> 00 when turning up.
  function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: t = TR_UP;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: t = TR_DN;
      4'b00_00, 4'b01_01, 4'b10_10, 4'b11_11: t = TR_NONE;
      default:                                t = TR_ILL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: 2-flop synchronizer then debouncer; stable follows after DEBOUNCE_CYCLES mismatches.
// Latency 2+DEBOUNCE_CYCLES edges from raw to stable; no backpressure (free-running).
module quad_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic load,
  output logic synced,
  output logic stable
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

  logic       meta;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
      // load snaps stable to the synchronized level at the end of INIT
      if (load) begin
        stable <= synced;
        cnt    <= '0;
      end else if (synced == stable) begin
        cnt <= '0;
      end else if (cnt + 8'd1 == CNT_MAX) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/quadrature_ctrl.sv
// Debounced quadrature decoder with detent accumulator and bounded wrap/saturate position counter.
// Latency 2+DEBOUNCE_CYCLES+1 edges raw-to-count; no backpressure, clear > load_en > rotation.
module quadrature_ctrl
  import quadrature_pkg::*;
#(
  parameter int          WIDTH            = 8,
  parameter int          DEBOUNCE_CYCLES  = 16,
  parameter int          STEPS_PER_DETENT = 4,
  parameter int unsigned MIN_VAL          = 0,
  parameter int unsigned MAX_VAL          = (1 << WIDTH) - 1,
  parameter bit          WRAP             = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             step_valid,
  output logic             step_dir,
  output logic             err
);

  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_VAL);
  localparam logic signed [3:0] ACC_TOP  = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] ACC_BOT  = -ACC_TOP;
  localparam logic [8:0]       INIT_LAST = 9'(2 + DEBOUNCE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [8:0]        init_cnt;
  logic              init_done;
  logic              syn_a, syn_b, stb_a, stb_b;
  logic [1:0]        prev, cur;
  trans_t            trans;
  logic signed [3:0] acc, acc_nxt;
  logic              up_req, dn_req, ill;
  logic [WIDTH-1:0]  count_nxt, load_clamped;
  logic              step_nxt, dir_nxt;

  assign init_done = (state == ST_INIT) && (init_cnt == INIT_LAST);
  assign cur       = {stb_a, stb_b};

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset_n(reset_n), .raw(quad_a), .load(init_done), .synced(syn_a), .stable(stb_a)
  );

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset_n(reset_n), .raw(quad_b), .load(init_done), .synced(syn_b), .stable(stb_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT && !init_done) init_cnt <= init_cnt + 9'd1;
      else                                init_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_done) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    trans = TR_NONE;
    if (state == ST_RUN) trans = decode_trans(prev, cur);
  end

  always_comb begin
    acc_nxt = acc;
    up_req  = 1'b0;
    dn_req  = 1'b0;
    ill     = 1'b0;
    case (trans)
      TR_UP: begin
        if (acc + 4'sd1 == ACC_TOP) begin acc_nxt = '0; up_req = 1'b1; end
        else                               acc_nxt = acc + 4'sd1;
      end
      TR_DN: begin
        if (acc - 4'sd1 == ACC_BOT) begin acc_nxt = '0; dn_req = 1'b1; end
        else                               acc_nxt = acc - 4'sd1;
      end
      TR_ILL: begin
        acc_nxt = '0;
        ill     = 1'b1;
      end
      default: ;
    endcase

    if (load_val <= MIN_W)      load_clamped = MIN_W;
    else if (load_val >= MAX_W) load_clamped = MAX_W;
    else                        load_clamped = load_val;

    count_nxt = count;
    step_nxt  = 1'b0;
    dir_nxt   = step_dir;
    // a detent landing with clear or load is dropped, not deferred
    if (clear) begin
      count_nxt = MIN_W;
      acc_nxt   = '0;
    end else if (load_en) begin
      count_nxt = load_clamped;
      acc_nxt   = '0;
    end else if (up_req) begin
      if (count != MAX_W) begin
        count_nxt = count + WIDTH'(1);
        step_nxt  = 1'b1;
        dir_nxt   = DIR_UP;
      end else if (WRAP) begin
        count_nxt = MIN_W;
        step_nxt  = 1'b1;
        dir_nxt   = DIR_UP;
      end
    end else if (dn_req) begin
      if (count != MIN_W) begin
        count_nxt = count - WIDTH'(1);
        step_nxt  = 1'b1;
        dir_nxt   = DIR_DN;
      end else if (WRAP) begin
        count_nxt = MAX_W;
        step_nxt  = 1'b1;
        dir_nxt   = DIR_DN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= MIN_W;
      acc        <= '0;
      prev       <= '0;
      step_valid <= 1'b0;
      step_dir   <= 1'b0;
      err        <= 1'b0;
    end else begin
      count      <= count_nxt;
      acc        <= acc_nxt;
      step_valid <= step_nxt;
      step_dir   <= dir_nxt;
      err        <= ill ? 1'b1 : (err_clr ? 1'b0 : err);
      if (init_done)            prev <= {syn_a, syn_b};
      else if (state == ST_RUN) prev <= cur;
    end
  end

endmodule

// File: tb/tb_quadrature_ctrl.sv
// Scoreboard bench: two DUT configurations share one stimulus stream; a detent-level model predicts steps.
// Wrap instance is 8-bit full range; saturate instance is 9-bit with MAX=200.
module tb_quadrature_ctrl;

  localparam int D   = 4;
  localparam int S   = 4;
  localparam int LAT = 3 + D;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       quad_a = 1'b0, quad_b = 1'b0;
  logic       clear = 1'b0, load_en = 1'b0, err_clr = 1'b0;
  logic [8:0] load_val = '0;
  logic [7:0] count0;
  logic [8:0] count1;
  logic       sv0, sv1, dir0, dir1, err0, err1;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quadrature_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEPS_PER_DETENT(S), .WRAP(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
    .load_en(load_en), .load_val(load_val[7:0]), .err_clr(err_clr),
    .count(count0), .step_valid(sv0), .step_dir(dir0), .err(err0)
  );

  quadrature_ctrl #(.WIDTH(9), .DEBOUNCE_CYCLES(D), .STEPS_PER_DETENT(S),
                    .MIN_VAL(0), .MAX_VAL(200), .WRAP(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
    .load_en(load_en), .load_val(load_val), .err_clr(err_clr),
    .count(count1), .step_valid(sv1), .step_dir(dir1), .err(err1)
  );

  typedef struct {
    int cyc;
    int cnt;
    bit dir;
  } exp_t;

  exp_t       q0[$], q1[$];
  int         checks = 0, failures = 0;
  int         m_cnt[2];
  int         m_acc;
  bit         m_err;
  logic [1:0] m_cur;
  logic [1:0] seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int hi_of(int id);
    return (id == 0) ? 255 : 200;
  endfunction

  function automatic int gidx(logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int id, int c, int cnt, bit dir);
    exp_t e;
    e.cyc = c; e.cnt = cnt; e.dir = dir;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic request(bit up, int k);
    for (int id = 0; id < 2; id++) begin
      int hi;
      bit wr;
      hi = hi_of(id);
      wr = (id == 0);
      if (up) begin
        if (m_cnt[id] < hi)  begin m_cnt[id]++; push(id, k + LAT, m_cnt[id], 1'b1); end
        else if (wr)         begin m_cnt[id] = 0; push(id, k + LAT, 0, 1'b1); end
      end else begin
        if (m_cnt[id] > 0)   begin m_cnt[id]--; push(id, k + LAT, m_cnt[id], 1'b0); end
        else if (wr)         begin m_cnt[id] = hi; push(id, k + LAT, hi, 1'b0); end
      end
    end
  endtask

  // Gray-position distance: 1 = forward, 3 = back, 2 = both bits flipped.
  task automatic model_trans(logic [1:0] s, int k, bit disc);
    int d;
    d = (gidx(s) - gidx(m_cur) + 4) % 4;
    m_cur = s;
    if (d == 2) begin
      m_err = 1'b1;
      m_acc = 0;
    end else if (d != 0) begin
      m_acc += (d == 1) ? 1 : -1;
      if (m_acc == S)       begin m_acc = 0; if (!disc) request(1'b1, k); end
      else if (m_acc == -S) begin m_acc = 0; if (!disc) request(1'b0, k); end
    end
    if (disc) begin m_cnt[0] = 0; m_cnt[1] = 0; m_acc = 0; end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // evt 1: clear lands on the decode edge; evt 2: err_clr lands on it
  task automatic drive(logic [1:0] s, int hold, int evt);
    int k;
    quad_a = s[1]; quad_b = s[0];
    k = cyc;
    model_trans(s, k, evt == 1);
    if (evt == 0) tick(hold);
    else begin
      tick(LAT - 1);
      if (evt == 1) clear = 1'b1; else err_clr = 1'b1;
      tick(1);
      clear = 1'b0; err_clr = 1'b0;
      tick(hold - LAT);
    end
  endtask

  task automatic quiet_pulse(int kind, logic [8:0] v);
    tick(8);
    case (kind)
      0:       clear = 1'b1;
      1:       begin load_en = 1'b1; load_val = v; end
      default: err_clr = 1'b1;
    endcase
    tick(1);
    clear = 1'b0; load_en = 1'b0; err_clr = 1'b0;
    case (kind)
      0: begin m_cnt[0] = 0; m_cnt[1] = 0; m_acc = 0; end
      1: begin
        for (int id = 0; id < 2; id++) begin
          int w;
          w = int'(v) % ((id == 0) ? 256 : 512);
          m_cnt[id] = (w > hi_of(id)) ? hi_of(id) : w;
        end
        m_acc = 0;
      end
      default: m_err = 1'b0;
    endcase
    tick(2);
  endtask

  task automatic do_reset(logic [1:0] rest);
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    m_cnt[0] = 0; m_cnt[1] = 0; m_acc = 0; m_err = 1'b0;
    quad_a = rest[1]; quad_b = rest[0]; m_cur = rest;
    tick(5);
    reset_n = 1'b1;
    tick(20);
  endtask

  task automatic mon_one(int id, int c, bit d);
    exp_t e;
    int   sz;
    sz = (id == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_step dut%0d: got step count=%0d dir=%0d at cyc %0d, expected no step", id, c, d, cyc);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    check($sformatf("step_cycle_dut%0d", id), cyc, e.cyc);
    check($sformatf("step_count_dut%0d", id), c, e.cnt);
    check($sformatf("step_dir_dut%0d", id), int'(d), int'(e.dir));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (sv0) mon_one(0, int'(count0), dir0);
        if (sv1) mon_one(1, int'(count1), dir1);
      end
    end
  endtask

  initial begin
    logic [1:0] nxt;
    int         r, hold;
    fork monitor(); join_none
    m_cnt[0] = 0; m_cnt[1] = 0; m_acc = 0; m_err = 1'b0; m_cur = 2'b00;

    tick(3);
    check("rst_count0", int'(count0), 0);
    check("rst_count1", int'(count1), 0);
    check("rst_step_valid", int'(sv0) + int'(sv1), 0);
    check("rst_step_dir", int'(dir0) + int'(dir1), 0);
    check("rst_err", int'(err0) + int'(err1), 0);
    reset_n = 1'b1;
    tick(20);

    drive(2'b10, 8, 0); drive(2'b11, 8, 0); drive(2'b01, 8, 0); drive(2'b00, 8, 0);
    check("cw_count0", int'(count0), 1);
    check("cw_count1", int'(count1), 1);
    check("cw_dir0", int'(dir0), 1);

    repeat (2) begin
      drive(2'b01, 8, 0); drive(2'b11, 8, 0); drive(2'b10, 8, 0); drive(2'b00, 8, 0);
    end
    check("ccw_wrap_count0", int'(count0), 255);
    check("ccw_sat_count1", int'(count1), 0);
    check("ccw_dir0", int'(dir0), 0);

    quad_a = 1'b1; tick(3); quad_a = 1'b0; tick(12);
    check("glitch_count0", int'(count0), 255);
    check("glitch_count1", int'(count1), 0);
    check("glitch_err", int'(err0) + int'(err1), 0);

    drive(2'b11, 12, 0);
    check("illegal_err0", int'(err0), 1);
    check("illegal_err1", int'(err1), 1);
    check("illegal_count0", int'(count0), 255);
    drive(2'b00, 12, 2);
    check("err_set_wins", int'(err0), 1);
    quiet_pulse(2, 9'd0);
    check("err_clr0", int'(err0), 0);
    check("err_clr1", int'(err1), 0);

    quiet_pulse(1, 9'd300);
    check("load_clamp_count1", int'(count1), 200);
    check("load_count0", int'(count0), 44);

    drive(2'b10, 8, 0); drive(2'b11, 8, 0); drive(2'b01, 8, 0); drive(2'b00, 10, 1);
    check("clear_vs_step_count0", int'(count0), 0);
    check("clear_vs_step_count1", int'(count1), 0);

    drive(2'b10, 8, 0); drive(2'b11, 3, 0);
    do_reset(2'b11);
    check("rst11_err", int'(err0) + int'(err1), 0);
    check("rst11_count0", int'(count0), 0);
    drive(2'b01, 8, 0); drive(2'b00, 8, 0); drive(2'b10, 8, 0); drive(2'b11, 8, 0);
    check("rst11_cw_count0", int'(count0), 1);
    check("rst11_cw_count1", int'(count1), 1);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      hold = int'($urandom_range(D + 2, D + 6));
      if (r < 3) begin
        tick(4);
        if (r == 0) begin quad_a = ~quad_a; tick(int'($urandom_range(1, 3))); quad_a = ~quad_a; end
        else        begin quad_b = ~quad_b; tick(int'($urandom_range(1, 3))); quad_b = ~quad_b; end
        tick(D + 4);
      end else if (r < 5) begin
        drive(m_cur ^ 2'b11, hold, 0);
      end else if (r < 7) begin
        quiet_pulse(1, 9'($urandom_range(0, 511)));
      end else if (r < 8) begin
        quiet_pulse(0, 9'd0);
      end else begin
        if ($urandom_range(0, 99) < 72) nxt = seq[(gidx(m_cur) + 1) % 4];
        else                            nxt = seq[(gidx(m_cur) + 3) % 4];
        drive(nxt, hold, 0);
      end
    end

    tick(20);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("final_count0", int'(count0), m_cnt[0]);
    check("final_count1", int'(count1), m_cnt[1]);
    check("final_err0", int'(err0), int'(m_err));
    check("final_err1", int'(err1), int'(m_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadrature_ctrl.md
QUADRATURE_CTRL -- requirements
Module: quadrature_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: position counter width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a synchronized input must differ from its stable value before the stable value updates; legal range 1..255.
REQ-003 Parameter STEPS_PER_DETENT, default 4: quadrature transitions per count step; legal values 1, 2, 4.
REQ-004 Parameters MIN_VAL, default 0, and MAX_VAL, default 2^WIDTH-1: inclusive counter bounds, unsigned.
REQ-005 Parameter WRAP, default 1: 1 means wrap at the bounds, 0 means saturate.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 quad_a, quad_b  in  1 each  raw asynchronous encoder channels.
REQ-009 clear  in  1  synchronous request: count <= MIN_VAL, accumulator <= 0.
REQ-010 load_en  in  1 / load_val  in  WIDTH  synchronous request: count <= load_val clamped to [MIN_VAL, MAX_VAL]; accumulator <= 0.
REQ-011 err_clr  in  1  clears err.
REQ-012 count  out  WIDTH  registered position.
REQ-013 step_valid  out  1  one-cycle pulse on the cycle count changes due to rotation.
REQ-014 step_dir  out  1  direction of the last step (1 = up); held between steps.
REQ-015 err  out  1  sticky flag for an illegal transition.

Function
REQ-016 Each channel shall pass through a 2-flop synchronizer, then a per-channel debouncer; the decoder shall see only the debounced {A,B}.
REQ-017 Debouncer: its counter increments on each cycle that synced != stable and resets to 0 on any cycle they match; stable shall update on the edge the counter reaches DEBOUNCE_CYCLES, and the counter shall return to 0 on that edge.
REQ-018 FSM states: INIT, RUN. Reset enters INIT; INIT lasts 2+DEBOUNCE_CYCLES cycles, then loads prev <= stable <= synced with no decode, then moves to RUN.
REQ-019 In RUN, transitions prev->stable of 00->10, 10->11, 11->01 and 01->00 shall be +1; the reverse transitions shall be -1; no change shall be 0.
REQ-020 A change of both bits in one cycle shall set err, zero the accumulator, leave count unchanged, and update prev.
REQ-021 A signed accumulator shall sum the transition values; at +STEPS_PER_DETENT it shall zero and request up, and at -STEPS_PER_DETENT it shall zero and request down.
REQ-022 An up request at MAX_VAL shall go to MIN_VAL if WRAP=1, otherwise hold with no step_valid; a down request at MIN_VAL shall be symmetric.
REQ-023 A count change from rotation shall take effect on the edge after the stable update, asserting step_valid for exactly that cycle with step_dir valid.
REQ-024 Total latency from a raw change held steady shall be 2+DEBOUNCE_CYCLES+1 edges to count/step_valid.
REQ-025 Priority in one cycle: clear > load_en > rotation step; a step coincident with clear or load shall be discarded with no step_valid.
REQ-026 err shall set on an illegal transition, clear on err_clr, and set take priority when both occur in the same cycle.
REQ-027 Inputs in INIT shall not change count or err except through clear, load_en and err_clr.

Reset
REQ-028 reset_n low, asynchronously: count = MIN_VAL; step_valid = 0; step_dir = 0; err = 0; accumulator, debounce counters, synchronizers, prev and stable = 0; state = INIT.
REQ-029 reset_n deasserted mid-rotation shall restart INIT, and no step shall be generated from pre-reset history.

Structure
REQ-030 Package quadrature_pkg shall hold the FSM state typedef, the transition-decode function ({prev,cur} -> -1/0/+1/illegal) and the direction constants.
REQ-031 Sub-module quad_debounce (synchronizer plus debouncer, one channel) shall be instantiated twice.

Verification
REQ-032 DEBOUNCE_CYCLES=4, STEPS=4: after INIT, apply the sequence 00->10->11->01->00 with each state held 8 cycles -> count 0->1, one step_valid, step_dir=1, 7 edges after the final change.
REQ-033 Reverse sequence from count=0, MIN=0, WRAP=1 -> count=255, step_dir=0; with WRAP=0 -> count stays 0 and no step_valid.
REQ-034 A 3-cycle glitch on quad_a (shorter than 4) -> stable unchanged, count unchanged, err=0.
REQ-035 Jump 00->11 in RUN -> err=1 and count unchanged; err_clr together with a second illegal jump -> err remains 1; err_clr alone -> err=0.
REQ-036 load_en with load_val=300 clamped, WIDTH=9, MAX=200 -> count=200; clear in the same cycle as a pending step -> count=MIN_VAL and no step_valid.
REQ-037 Power up with the encoder resting at 11, release reset -> no err and no step; a subsequent legal CW detent -> count +1.
